// File: rtl/cpu_pkg.sv
// Shared decode definitions: operation classes, immediate formats,
// RV32I major opcodes and the decode FSM state type.
package cpu_pkg;

  typedef enum logic [3:0] {
    CLS_NOP    = 4'd0,
    CLS_OP     = 4'd1,
    CLS_OP_IMM = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9,
    CLS_SYSTEM = 4'd10,
    CLS_FENCE  = 4'd11
  } op_class_t;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_LATCH = 2'd2,
    S_VALID = 2'd3
  } dec_state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

endpackage

// File: rtl/cpu_decode_imm.sv
// Combinational RV32I immediate generator; shared with the branch predictor.
module cpu_decode_imm
  import cpu_pkg::*;
(
  input  logic [31:0] i_instruction,
  input  imm_fmt_t    i_fmt,
  output logic [31:0] o_imm
);

  // Opcode bits never contribute to an immediate.
  logic w_unused_opcode;
  assign w_unused_opcode = ^i_instruction[6:0];

  // Select and sign-extend the immediate bits for the given format.
  always_comb begin
    o_imm = 32'd0;
    case (i_fmt)
      FMT_I: o_imm = {{20{i_instruction[31]}}, i_instruction[31:20]};
      FMT_S: o_imm = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
      FMT_B: o_imm = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                      i_instruction[30:25], i_instruction[11:8], 1'b0};
      FMT_U: o_imm = {i_instruction[31:12], 12'd0};
      FMT_J: o_imm = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                      i_instruction[20], i_instruction[30:21], 1'b0};
      default: o_imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/cpu_decode.sv
// RV32I decode stage with a one-entry skid buffer toward fetch.
// Optional macro DECODE_ILLEGAL_TRAP_EN adds the o_illegal output.
module cpu_decode
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
)
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_fetch_ready,
  input  logic [31:0] i_fetch_instruction,
  input  logic [31:0] i_fetch_pc,
  output logic        o_fetch_stall,
  input  logic        i_flush,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output logic        o_valid,
  input  logic        i_execute_ready,
  output logic [3:0]  o_op,
  output logic [2:0]  o_funct3,
  output logic        o_funct7b5,
  output logic [4:0]  o_rd,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  output logic [31:0] o_imm,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction,
  output logic        o_overflow
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic        o_illegal
`endif
);

  dec_state_t  r_state, w_state_nxt;
  logic [31:0] r_work_instr, r_work_pc, r_buf_instr, r_buf_pc;
  logic        r_buf_vld, r_valid, r_overflow;
  op_class_t   r_op, w_op;
  imm_fmt_t    w_fmt;
  logic [2:0]  r_funct3;
  logic        r_funct7b5, w_has_rd, w_illegal, w_accept;
  logic [4:0]  r_rd, w_rd;
  logic [31:0] r_rs1_data, r_rs2_data, r_imm, r_pc, r_instr, w_imm;
  logic        w_work_ld, w_work_from_buf, w_buf_ld, w_buf_clr;
  logic        w_out_ld, w_valid_clr, w_ovf_set;

  assign w_accept      = r_valid && i_execute_ready;
  assign o_fetch_stall = r_buf_vld;
  assign o_rs1_addr    = r_work_instr[19:15];
  assign o_rs2_addr    = r_work_instr[24:20];

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and datapath load controls; flush overrides everything.
  always_comb begin
    w_state_nxt     = r_state;
    w_work_ld       = 1'b0;
    w_work_from_buf = 1'b0;
    w_buf_ld        = 1'b0;
    w_buf_clr       = 1'b0;
    w_out_ld        = 1'b0;
    w_valid_clr     = 1'b0;
    w_ovf_set       = 1'b0;
    if (i_flush) begin
      w_buf_clr   = 1'b1;
      w_valid_clr = 1'b1;
      if (i_fetch_ready) begin
        w_work_ld   = 1'b1;
        w_state_nxt = S_READ;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end else begin
      case (r_state)
        S_IDLE: if (i_fetch_ready) begin
          w_work_ld   = 1'b1;
          w_state_nxt = S_READ;
        end
        S_READ:  w_state_nxt = S_LATCH;
        S_LATCH: begin
          w_out_ld    = 1'b1;
          w_state_nxt = S_VALID;
        end
        S_VALID: if (w_accept) begin
          w_valid_clr = 1'b1;
          if (r_buf_vld) begin
            w_work_ld       = 1'b1;
            w_work_from_buf = 1'b1;
            w_buf_clr       = 1'b1;
            w_state_nxt     = S_READ;
          end else if (i_fetch_ready) begin
            w_work_ld   = 1'b1;
            w_state_nxt = S_READ;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      // A busy stage parks the strobe in the buffer; a buffer freed by the
      // same-edge accept can take it, otherwise it is dropped and flagged.
      if (i_fetch_ready && (r_state != S_IDLE) &&
          !((r_state == S_VALID) && w_accept && !r_buf_vld)) begin
        if (!r_buf_vld || ((r_state == S_VALID) && w_accept)) w_buf_ld  = 1'b1;
        else                                                  w_ovf_set = 1'b1;
      end
    end
  end

  // Classify the work instruction; illegal encodings collapse to NOP, rd=0.
  always_comb begin
    w_op      = CLS_NOP;
    w_fmt     = FMT_R;
    w_has_rd  = 1'b0;
    w_illegal = 1'b0;
    case (r_work_instr[6:0])
      OPC_OP: begin
        if ((r_work_instr[31:25] == 7'b0000000) || (r_work_instr[31:25] == 7'b0100000)) begin
          w_op     = CLS_OP;
          w_has_rd = 1'b1;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin w_op = CLS_OP_IMM; w_fmt = FMT_I; w_has_rd = 1'b1; end
      OPC_LOAD:   begin w_op = CLS_LOAD;   w_fmt = FMT_I; w_has_rd = 1'b1; end
      OPC_STORE:  begin w_op = CLS_STORE;  w_fmt = FMT_S; end
      OPC_BRANCH: begin w_op = CLS_BRANCH; w_fmt = FMT_B; end
      OPC_JAL:    begin w_op = CLS_JAL;    w_fmt = FMT_J; w_has_rd = 1'b1; end
      OPC_JALR:   begin w_op = CLS_JALR;   w_fmt = FMT_I; w_has_rd = 1'b1; end
      OPC_LUI:    begin w_op = CLS_LUI;    w_fmt = FMT_U; w_has_rd = 1'b1; end
      OPC_AUIPC:  begin w_op = CLS_AUIPC;  w_fmt = FMT_U; w_has_rd = 1'b1; end
      OPC_SYSTEM: begin w_op = CLS_SYSTEM; w_fmt = FMT_I; w_has_rd = 1'b1; end
      OPC_FENCE:  begin w_op = CLS_FENCE;  w_fmt = FMT_I; end
      default:    w_illegal = 1'b1;
    endcase
    if (r_work_instr[1:0] != 2'b11) w_illegal = 1'b1;
    if (w_illegal) begin
      w_op     = CLS_NOP;
      w_fmt    = FMT_R;
      w_has_rd = 1'b0;
    end
  end

  assign w_rd = w_has_rd ? r_work_instr[11:7] : 5'd0;

  cpu_decode_imm u_imm (
    .i_instruction (r_work_instr),
    .i_fmt         (w_fmt),
    .o_imm         (w_imm)
  );

  // Work register, skid buffer and sticky overflow flag.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_work_instr <= 32'd0;
      r_work_pc    <= 32'd0;
      r_buf_instr  <= 32'd0;
      r_buf_pc     <= 32'd0;
      r_buf_vld    <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_work_ld) begin
        r_work_instr <= w_work_from_buf ? r_buf_instr : i_fetch_instruction;
        r_work_pc    <= w_work_from_buf ? r_buf_pc    : i_fetch_pc;
      end
      if (w_buf_ld) begin
        r_buf_instr <= i_fetch_instruction;
        r_buf_pc    <= i_fetch_pc;
        r_buf_vld   <= 1'b1;
      end else if (w_buf_clr) begin
        r_buf_vld <= 1'b0;
      end
      if (w_ovf_set) r_overflow <= 1'b1;
    end
  end

  // Decoded packet register, held stable while waiting for execute.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_valid    <= 1'b0;
      r_op       <= CLS_NOP;
      r_funct3   <= 3'd0;
      r_funct7b5 <= 1'b0;
      r_rd       <= 5'd0;
      r_rs1_data <= 32'd0;
      r_rs2_data <= 32'd0;
      r_imm      <= 32'd0;
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
    end else if (w_out_ld) begin
      r_valid    <= 1'b1;
      r_op       <= w_op;
      r_funct3   <= r_work_instr[14:12];
      r_funct7b5 <= r_work_instr[30];
      r_rd       <= w_rd;
      r_rs1_data <= (o_rs1_addr == 5'd0) ? 32'd0 : i_rs1_data;
      r_rs2_data <= (o_rs2_addr == 5'd0) ? 32'd0 : i_rs2_data;
      r_imm      <= w_imm;
      r_pc       <= r_work_pc;
      r_instr    <= r_work_instr;
    end else if (w_valid_clr) begin
      r_valid <= 1'b0;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic r_illegal;

  // Illegal flag travels with the packet.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)       r_illegal <= 1'b0;
    else if (w_out_ld) r_illegal <= w_illegal;
  end

  assign o_illegal = r_illegal;
`endif

  assign o_valid       = r_valid;
  assign o_op          = r_op;
  assign o_funct3      = r_funct3;
  assign o_funct7b5    = r_funct7b5;
  assign o_rd          = r_rd;
  assign o_rs1_data    = r_rs1_data;
  assign o_rs2_data    = r_rs2_data;
  assign o_imm         = r_imm;
  assign o_pc          = r_pc;
  assign o_instruction = r_instr;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_cpu_decode.sv
// Self-checking bench for cpu_decode: vector table plus handshake sequences,
// with a packet scoreboard and a synchronous register-file model.
module tb_cpu_decode;
  import cpu_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_ready = 1'b0;
  logic [31:0] fetch_instr = 32'd0;
  logic [31:0] fetch_pc = 32'd0;
  logic        flush = 1'b0;
  logic        exe_ready = 1'b0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        o_fetch_stall, o_valid, o_funct7b5, o_overflow;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd;
  logic [3:0]  o_op;
  logic [2:0]  o_funct3;
  logic [31:0] o_rs1_data, o_rs2_data, o_imm, o_pc, o_instruction;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        o_illegal;
`endif

  cpu_decode #(.RESET_PC(TB_RESET_PC)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_fetch_ready(fetch_ready), .i_fetch_instruction(fetch_instr), .i_fetch_pc(fetch_pc),
    .o_fetch_stall(o_fetch_stall), .i_flush(flush),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .i_rs1_data(rs1_data), .i_rs2_data(rs2_data),
    .o_valid(o_valid), .i_execute_ready(exe_ready),
    .o_op(o_op), .o_funct3(o_funct3), .o_funct7b5(o_funct7b5), .o_rd(o_rd),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm(o_imm), .o_pc(o_pc),
    .o_instruction(o_instruction), .o_overflow(o_overflow)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .o_illegal(o_illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        f7b5;
    logic        ill;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Register file contents; x0 deliberately reads nonzero so forcing is visible.
  function automatic logic [31:0] rf(input logic [4:0] a);
    if (a == 5'd0) return 32'hDEAD_BEEF;
    return {27'd0, a} * 32'd7;
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf(a);
  endfunction

  always @(posedge clk) begin
    rs1_data <= rf(o_rs1_addr);
    rs2_data <= rf(o_rs2_addr);
  end

  // Compare every packet that execute takes against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && o_valid && exe_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_packet actual_pc=0x%08h required=none", o_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pkt_pc",    o_pc,          e.pc);
        chk("pkt_instr", o_instruction, e.v.instr);
        chk("pkt_op",    32'(o_op),     32'(e.v.op));
        chk("pkt_rd",    32'(o_rd),     32'(e.v.rd));
        chk("pkt_imm",   o_imm,         e.v.imm);
        chk("pkt_f3",    32'(o_funct3), 32'(e.v.f3));
        chk("pkt_f7b5",  32'(o_funct7b5), 32'(e.v.f7b5));
        chk("pkt_rs1",   o_rs1_data,    e.rs1d);
        chk("pkt_rs2",   o_rs2_data,    e.rs2d);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("pkt_illegal", 32'(o_illegal), 32'(e.v.ill));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle fetch strobe; keep=1 when the instruction must reach execute.
  task automatic fetch(input int idx, input logic [31:0] pc, input bit keep);
    exp_t e;
    fetch_ready = 1'b1;
    fetch_instr = vecs[idx].instr;
    fetch_pc    = pc;
    if (keep) begin
      e.v    = vecs[idx];
      e.pc   = pc;
      e.rs1d = opnd(vecs[idx].instr[19:15]);
      e.rs2d = opnd(vecs[idx].instr[24:20]);
      sb.push_back(e);
    end
    tick();
    fetch_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 12) begin
      tick();
      n++;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'hFFD08293, CLS_OP_IMM, 5'd5,  32'hFFFFFFFD, 3'd0, 1'b1, 1'b0};
    vecs[1]  = '{32'h00208863, CLS_BRANCH, 5'd0,  32'h00000010, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{32'hFF9FF0EF, CLS_JAL,    5'd1,  32'hFFFFFFF8, 3'd7, 1'b1, 1'b0};
    vecs[3]  = '{32'h123451B7, CLS_LUI,    5'd3,  32'h12345000, 3'd5, 1'b0, 1'b0};
    vecs[4]  = '{32'h0020A423, CLS_STORE,  5'd0,  32'h00000008, 3'd2, 1'b0, 1'b0};
    vecs[5]  = '{32'h402003B3, CLS_OP,     5'd7,  32'h00000000, 3'd0, 1'b1, 1'b0};
    vecs[6]  = '{32'h00000000, CLS_NOP,    5'd0,  32'h00000000, 3'd0, 1'b0, 1'b1};
    vecs[7]  = '{32'h004280E7, CLS_JALR,   5'd1,  32'h00000004, 3'd0, 1'b0, 1'b0};
    vecs[8]  = '{32'hFFFFF517, CLS_AUIPC,  5'd10, 32'hFFFFF000, 3'd7, 1'b1, 1'b0};
    vecs[9]  = '{32'hFFC12203, CLS_LOAD,   5'd4,  32'hFFFFFFFC, 3'd2, 1'b1, 1'b0};
    vecs[10] = '{32'h00000073, CLS_SYSTEM, 5'd0,  32'h00000000, 3'd0, 1'b0, 1'b0};
    vecs[11] = '{32'h0FF0008F, CLS_FENCE,  5'd0,  32'h000000FF, 3'd0, 1'b0, 1'b0};
    vecs[12] = '{32'h020000B3, CLS_NOP,    5'd0,  32'h00000000, 3'd0, 1'b0, 1'b1};
    vecs[13] = '{32'h00000010, CLS_NOP,    5'd0,  32'h00000000, 3'd0, 1'b0, 1'b1};

    // Reset state
    tick(); tick();
    chk("rst_valid",    32'(o_valid),       32'd0);
    chk("rst_pc",       o_pc,               TB_RESET_PC);
    chk("rst_stall",    32'(o_fetch_stall), 32'd0);
    chk("rst_overflow", 32'(o_overflow),    32'd0);
    chk("rst_imm",      o_imm,              32'd0);
    chk("rst_rs1_addr", 32'(o_rs1_addr),    32'd0);
    rst = 1'b0;
    tick();

    // Latency of the first ADDI and register read addresses
    fetch(0, 32'h0000_0040, 1'b1);
    chk("read_rs1_addr", 32'(o_rs1_addr), 32'd1);
    chk("read_rs2_addr", 32'(o_rs2_addr), 32'd29);
    chk("lat_edge1", 32'(o_valid), 32'd0);
    tick();
    chk("lat_edge2", 32'(o_valid), 32'd0);
    tick();
    chk("lat_edge3", 32'(o_valid), 32'd1);
    exe_ready = 1'b1;
    drain("drain_addi");
    chk("addi_valid_drop", 32'(o_valid), 32'd0);

    // Back-pressure: packet, buffered second, dropped third
    exe_ready = 1'b0;
    fetch(3, 32'h0000_0200, 1'b1);
    fetch(4, 32'h0000_0204, 1'b1);
    chk("buf_stall", 32'(o_fetch_stall), 32'd1);
    tick();
    chk("buf_first_valid", 32'(o_valid), 32'd1);
    fetch(8, 32'h0000_0208, 1'b0);
    chk("ovf_set",   32'(o_overflow),    32'd1);
    chk("ovf_stall", 32'(o_fetch_stall), 32'd1);
    tick(); tick();
    chk("hold_valid", 32'(o_valid), 32'd1);
    chk("hold_pc",    o_pc,         32'h0000_0200);
    exe_ready = 1'b1;
    tick();
    chk("accept_stall_clr", 32'(o_fetch_stall), 32'd0);
    chk("accept_valid_clr", 32'(o_valid),       32'd0);
    tick();
    chk("buf_lat1", 32'(o_valid), 32'd0);
    tick();
    chk("buf_lat2", 32'(o_valid), 32'd1);
    drain("drain_buf");
    repeat (4) tick();
    chk("dropped_absent", 32'(o_valid),    32'd0);
    chk("ovf_sticky",     32'(o_overflow), 32'd1);

    // Table of decode vectors, one at a time
    exe_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      fetch(i, 32'h0000_1000 + 32'(i * 4), 1'b1);
      drain($sformatf("vec%0d", i));
    end

    // Strobe and accept on the same edge with an empty buffer
    fetch(1, 32'h0000_0400, 1'b1);
    tick(); tick();
    chk("same_first_valid", 32'(o_valid), 32'd1);
    fetch(2, 32'h0000_0404, 1'b1);
    chk("same_stall", 32'(o_fetch_stall), 32'd0);
    chk("same_valid", 32'(o_valid),       32'd0);
    tick();
    chk("same_lat1", 32'(o_valid), 32'd0);
    tick();
    chk("same_lat2", 32'(o_valid), 32'd1);
    drain("drain_same");

    // Flush with valid packet and full buffer, branch target strobe alongside
    exe_ready = 1'b0;
    fetch(1, 32'h0000_0300, 1'b0);
    fetch(2, 32'h0000_0304, 1'b0);
    tick();
    chk("pre_flush_valid", 32'(o_valid),       32'd1);
    chk("pre_flush_stall", 32'(o_fetch_stall), 32'd1);
    flush = 1'b1;
    fetch(0, 32'h0000_0100, 1'b1);
    flush = 1'b0;
    chk("flush_valid", 32'(o_valid),       32'd0);
    chk("flush_stall", 32'(o_fetch_stall), 32'd0);
    exe_ready = 1'b1;
    drain("drain_flush");

    // Asynchronous reset while an instruction sits in S_LATCH
    exe_ready = 1'b0;
    fetch(5, 32'h0000_0500, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid",    32'(o_valid),    32'd0);
    chk("arst_pc",       o_pc,            TB_RESET_PC);
    chk("arst_overflow", 32'(o_overflow), 32'd0);
    chk("arst_imm",      o_imm,           32'd0);
    chk("arst_instr",    o_instruction,   32'd0);
    chk("arst_rd",       32'(o_rd),       32'd0);
    chk("arst_op",       32'(o_op),       32'd0);
    chk("arst_rs1_addr", 32'(o_rs1_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exe_ready = 1'b1;
    repeat (4) tick();
    chk("arst_discard", 32'(o_valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
